mem_stage_sram_lb: RTL and testbench
====================================

# mem_stage_sram_lb

Parametrised memory stage for the pipelined ARM core, sitting between the EXE/MEM and MEM/WB pipeline registers. It embeds a multi-cycle SRAM controller FSM with configurable SRAM word width, address width, base offset and wait-state count. A one-entry line buffer holds the most recently read SRAM word, so back-to-back reads of the same word complete without touching the SRAM. The block stalls the pipeline through `ready` while an SRAM access is in flight.

## Interface
Parameters:
- `SRAM_DW`, 64, SRAM data width; a multiple of 32; `LANES = SRAM_DW/32`
- `SRAM_AW`, 17, SRAM word-address width
- `BASE_ADDR`, 1024, byte offset subtracted from `alu_res` before decode
- `WAIT_CYCLES`, 5, SRAM access cycles per read or write; must be ≥1
- `LB_EN`, 1, enables the line buffer; when 0, every read misses

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-low
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in`  in  1  control signals from EXE
- `dest_in`  in  4  destination register
- `val_rm`  in  32  write data
- `alu_res`  in  32  byte address / ALU result
- `ready`  out  1  high when the stage can advance; low means stall
- `mem_r_en_out`, `wb_en_out`, `dest_out`, `alu_res_out`  out  1/1/4/32  combinational pass-through
- `mem_out`  out  32  read data
- `sram_addr`  out  SRAM_AW  word address
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`  out  1  SRAM strobes, active-low
- `sram_be_n`  out  SRAM_DW/8  byte enables, active-low
- `sram_dq`  inout  SRAM_DW  SRAM data bus

## Operation
- Address decode:
  - `off = alu_res - BASE_ADDR`, computed modulo 2^32.
  - Word address: `off[log2(SRAM_DW/8) +: SRAM_AW]`.
  - Lane: `off[2 +: log2(LANES)]`.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Write request (`mem_w_en_in`) → WRITE. Write has priority if both enables are high.
  - Read request that misses the line buffer → READ.
  - Read hit → stay in IDLE, no SRAM strobes.
- READ:
  - `sram_ce_n=0`, `sram_oe_n=0`, `sram_dq` is high-Z.
  - A counter runs 0..WAIT_CYCLES-1.
  - On the last count: capture `sram_dq` into the line buffer (data, tag = word address, valid=1), then → DONE.
- WRITE:
  - `sram_ce_n=0`, `sram_we_n=0`.
  - The selected lane of `sram_dq` is driven with `val_rm`; all other lanes are high-Z.
  - `sram_be_n` is low only for the 4 bytes of that lane.
  - On the last count → DONE. If the line buffer is valid and the tag matches, its lane is updated with `val_rm` (write-through).
- DONE: all strobes are deasserted; → IDLE unconditionally.
- `ready` (combinational):
  - 1 when there is no request, in DONE, or on a read hit.
  - 0 otherwise.
  - Forced to 1 while `rst=0`.
- `mem_out`:
  - Read hit: buffer lane from the current address.
  - DONE after a read: the captured lane.
  - Otherwise: 0.
- Reset (including mid-access): next edge → IDLE, counter 0, line buffer invalid.
  - `sram_we_n`, `sram_oe_n`, `sram_ce_n` = 1; `sram_be_n` all 1s; `sram_dq` high-Z; `mem_out` = 0.
- Upstream holds all inputs stable while `ready=0`.

## Timing
- Request first seen at cycle 0 (IDLE) → strobes active in cycles 1..WAIT_CYCLES → DONE in cycle WAIT_CYCLES+1 with `ready=1` → IDLE in cycle WAIT_CYCLES+2.
- Miss or write: `ready` is low for exactly WAIT_CYCLES+1 cycles.
- Read hit: 0-cycle latency; `ready` and `mem_out` are valid in the same cycle.
- There is one IDLE bubble between back-to-back SRAM accesses.
- Strobes and `sram_addr` are registered and glitch-free. `sram_addr` is held constant throughout an access.

## Structure
- Package `mem_pkg`: state enum (IDLE/READ/WRITE/DONE), `LANES` and lane-bit-width localparams, and the byte-enable decode function.
- Sub-module `sram_ctrl_fsm`: state register, wait counter, strobes, DQ tri-state drive.
- Top level: address decode, line buffer, `mem_out` mux, pass-throughs.

## Test plan
- Read miss: `alu_res=1032`, SRAM returns `64'hDEADBEEF_12345678` → `ready` low for 6 cycles, high in cycle 6 with `mem_out=0x12345678`, `sram_addr=1`.
- Read hit: after the miss above, read `alu_res=1036` → `ready=1` same cycle, `mem_out=0xDEADBEEF`, `sram_oe_n` stays 1.
- Write lane 1: `alu_res=1036`, `val_rm=0xCAFEF00D` → `sram_we_n` low cycles 1–5, `sram_be_n=8'h0F`, `sram_dq[63:32]=0xCAFEF00D`, `sram_dq[31:0]` high-Z. A following read of 1036 hits with `0xCAFEF00D`.
- Reset mid-read: `rst=0` in cycle 3 of a miss → all strobes high next edge, `ready=1`. Re-reading the same address then misses and takes 6 cycles.
- Simultaneous `mem_r_en_in`/`mem_w_en_in` plus pass-through checks: FSM performs a write. `wb_en_out`, `dest_out`, `alu_res_out` track their inputs combinationally in every state.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the SRAM-backed memory stage.
// State encoding, lane geometry and byte-enable decode.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mem_state_e;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned DEF_SRAM_DW = 64;
    localparam int unsigned DEF_LANES   = DEF_SRAM_DW / WORD_W;

    function automatic int unsigned lane_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int unsigned DEF_LANE_W = lane_w(DEF_LANES);

    // Active-low enables for one 4-byte lane of the SRAM word.
    function automatic logic [3:0] lane_be_n(input int unsigned idx,
                                             input int unsigned sel);
        return (idx == sel) ? 4'h0 : 4'hF;
    endfunction

endpackage

// File: rtl/sram_ctrl_fsm.sv
// Multi-cycle SRAM access sequencer: state, wait counter,
// registered strobes and per-lane tri-state data drive.
module sram_ctrl_fsm
    import mem_pkg::*;
#(
    parameter int unsigned SRAM_DW     = 64,
    parameter int unsigned SRAM_AW     = 17,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned LANE_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_i,
    input  logic                 wr_req_i,
    input  logic [SRAM_AW-1:0]   waddr_i,
    input  logic [LANE_W-1:0]    lane_i,
    input  logic [31:0]          wdata_i,
    output logic                 idle_o,
    output logic                 done_o,
    output logic                 was_rd_o,
    output logic                 last_rd_o,
    output logic                 last_wr_o,
    output logic [SRAM_AW-1:0]   sram_addr_o,
    output logic                 sram_we_n_o,
    output logic                 sram_oe_n_o,
    output logic                 sram_ce_n_o,
    output logic [SRAM_DW/8-1:0] sram_be_n_o,
    inout  wire  [SRAM_DW-1:0]   sram_dq
);

    localparam int unsigned LANES = SRAM_DW / 32;
    localparam int unsigned CNT_W =
        (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 was_rd_q, was_rd_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 ce_n_q, ce_n_d;
    logic [SRAM_DW/8-1:0] be_n_q, be_n_d;
    logic [LANES-1:0]     drv_q, drv_d;
    logic                 last;

    assign last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        was_rd_d = was_rd_q;
        addr_d   = addr_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req_i) begin
                    state_d  = WRITE;
                    was_rd_d = 1'b0;
                    addr_d   = waddr_i;
                    lane_d   = lane_i;
                    wdata_d  = wdata_i;
                    cnt_d    = '0;
                end else if (rd_req_i) begin
                    state_d  = READ;
                    was_rd_d = 1'b1;
                    addr_d   = waddr_i;
                    lane_d   = lane_i;
                    cnt_d    = '0;
                end
            end
            READ, WRITE: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they change only on the edge.
        ce_n_d = !((state_d == READ) || (state_d == WRITE));
        oe_n_d = (state_d != READ);
        we_n_d = (state_d != WRITE);
        for (int l = 0; l < LANES; l++) begin
            be_n_d[l*4 +: 4] = (state_d == WRITE)
                ? lane_be_n(l, int'(lane_d)) : 4'hF;
            drv_d[l] = (state_d == WRITE) && (lane_d == LANE_W'(l));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            was_rd_q <= 1'b0;
            addr_q   <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ce_n_q   <= 1'b1;
            be_n_q   <= '1;
            drv_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            was_rd_q <= was_rd_d;
            addr_q   <= addr_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            ce_n_q   <= ce_n_d;
            be_n_q   <= be_n_d;
            drv_q    <= drv_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_dq
        assign sram_dq[g*32 +: 32] = drv_q[g] ? wdata_q : {32{1'bz}};
    end

    assign idle_o      = (state_q == IDLE);
    assign done_o      = (state_q == DONE);
    assign was_rd_o    = was_rd_q;
    assign last_rd_o   = (state_q == READ) && last;
    assign last_wr_o   = (state_q == WRITE) && last;
    assign sram_addr_o = addr_q;
    assign sram_we_n_o = we_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_be_n_o = be_n_q;

endmodule

// File: rtl/mem_stage_sram_lb.sv
// Memory stage: address decode, one-entry line buffer,
// read-data mux and stall generation around the SRAM sequencer.
module mem_stage_sram_lb
    import mem_pkg::*;
#(
    parameter int unsigned SRAM_DW     = 64,
    parameter int unsigned SRAM_AW     = 17,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned LB_EN       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_r_en_in,
    input  logic                 mem_w_en_in,
    input  logic                 wb_en_in,
    input  logic [3:0]           dest_in,
    input  logic [31:0]          val_rm,
    input  logic [31:0]          alu_res,
    output logic                 ready,
    output logic                 mem_r_en_out,
    output logic                 wb_en_out,
    output logic [3:0]           dest_out,
    output logic [31:0]          alu_res_out,
    output logic [31:0]          mem_out,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic                 sram_we_n,
    output logic                 sram_oe_n,
    output logic                 sram_ce_n,
    output logic [SRAM_DW/8-1:0] sram_be_n,
    inout  wire  [SRAM_DW-1:0]   sram_dq
);

    localparam int unsigned LANES   = SRAM_DW / 32;
    localparam int unsigned LANE_W  = lane_w(LANES);
    localparam int unsigned BYTE_SH = $clog2(SRAM_DW / 8);

    logic [31:0]        off;
    logic [SRAM_AW-1:0] waddr;
    logic [LANE_W-1:0]  lane;
    logic               unused_off;

    assign off        = alu_res - 32'(BASE_ADDR);
    assign waddr      = off[BYTE_SH +: SRAM_AW];
    assign lane       = (LANES > 1) ? off[2 +: LANE_W] : '0;
    assign unused_off = ^off;

    logic               lb_valid_q, lb_valid_d;
    logic [SRAM_AW-1:0] lb_tag_q, lb_tag_d;
    logic [SRAM_DW-1:0] lb_data_q, lb_data_d;

    logic idle, done, was_rd, last_rd, last_wr;
    logic hit, rd_req;

    assign hit = (LB_EN != 0) && idle && lb_valid_q
              && (lb_tag_q == waddr)
              && mem_r_en_in && !mem_w_en_in;
    assign rd_req = mem_r_en_in && !hit;

    sram_ctrl_fsm #(
        .SRAM_DW     (SRAM_DW),
        .SRAM_AW     (SRAM_AW),
        .WAIT_CYCLES (WAIT_CYCLES),
        .LANE_W      (LANE_W)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .rd_req_i    (rd_req),
        .wr_req_i    (mem_w_en_in),
        .waddr_i     (waddr),
        .lane_i      (lane),
        .wdata_i     (val_rm),
        .idle_o      (idle),
        .done_o      (done),
        .was_rd_o    (was_rd),
        .last_rd_o   (last_rd),
        .last_wr_o   (last_wr),
        .sram_addr_o (sram_addr),
        .sram_we_n_o (sram_we_n),
        .sram_oe_n_o (sram_oe_n),
        .sram_ce_n_o (sram_ce_n),
        .sram_be_n_o (sram_be_n),
        .sram_dq     (sram_dq)
    );

    // Data is always captured so DONE can return it even without the buffer.
    always_comb begin
        lb_valid_d = lb_valid_q;
        lb_tag_d   = lb_tag_q;
        lb_data_d  = lb_data_q;
        if (last_rd) begin
            lb_data_d  = sram_dq;
            lb_tag_d   = sram_addr;
            lb_valid_d = (LB_EN != 0);
        end else if (last_wr && lb_valid_q && (lb_tag_q == sram_addr)) begin
            lb_data_d[{lane, 5'b0} +: 32] = val_rm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
        end else begin
            lb_valid_q <= lb_valid_d;
            lb_tag_q   <= lb_tag_d;
            lb_data_q  <= lb_data_d;
        end
    end

    always_comb begin
        if (!rst) begin
            ready = 1'b1;
        end else if (done || hit) begin
            ready = 1'b1;
        end else if (idle) begin
            ready = !(mem_r_en_in || mem_w_en_in);
        end else begin
            ready = 1'b0;
        end
    end

    always_comb begin
        mem_out = '0;
        if (rst && (hit || (done && was_rd))) begin
            mem_out = lb_data_q[{lane, 5'b0} +: 32];
        end
    end

    assign mem_r_en_out = mem_r_en_in;
    assign wb_en_out    = wb_en_in;
    assign dest_out     = dest_in;
    assign alu_res_out  = alu_res;

endmodule

// File: tb/tb_mem_stage_sram_lb.sv
// Directed bench for mem_stage_sram_lb with a transaction-level
// reference model checked every cycle plus literal expectations.
module tb_mem_stage_sram_lb;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in;
    logic [3:0]  dest_in;
    logic [31:0] val_rm, alu_res;
    logic        ready, mem_r_en_out, wb_en_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_res_out, mem_out;
    logic [16:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n;
    logic [7:0]  sram_be_n;
    wire  [63:0] sram_dq;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_stage_sram_lb dut (
        .clk          (clk),
        .rst          (rst),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .wb_en_in     (wb_en_in),
        .dest_in      (dest_in),
        .val_rm       (val_rm),
        .alu_res      (alu_res),
        .ready        (ready),
        .mem_r_en_out (mem_r_en_out),
        .wb_en_out    (wb_en_out),
        .dest_out     (dest_out),
        .alu_res_out  (alu_res_out),
        .mem_out      (mem_out),
        .sram_addr    (sram_addr),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n),
        .sram_ce_n    (sram_ce_n),
        .sram_be_n    (sram_be_n),
        .sram_dq      (sram_dq)
    );

    // External SRAM device
    logic [63:0] sram_arr [16] = '{1: 64'hDEADBEEF_12345678,
                                   2: 64'h01234567_89ABCDEF,
                                   default: 64'h0};

    assign sram_dq = (!sram_oe_n && !sram_ce_n)
                   ? sram_arr[sram_addr[3:0]] : {64{1'bz}};

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 8; b++) begin
                if (!sram_be_n[b])
                    sram_arr[sram_addr[3:0]][b*8 +: 8] <= sram_dq[b*8 +: 8];
            end
        end
    end

    function automatic logic [16:0] f_wa(input logic [31:0] a);
        return 17'((a - BASE) / 8);
    endfunction

    function automatic int f_ln(input logic [31:0] a);
        return int'(((a - BASE) / 4) % 2);
    endfunction

    // Reference model: phase 0 idle, 1..W SRAM busy, W+1 completion
    logic [63:0] mdl_mem [16] = '{1: 64'hDEADBEEF_12345678,
                                  2: 64'h01234567_89ABCDEF,
                                  default: 64'h0};
    int          phase = 0;
    logic        op_rd = 1'b0;
    logic [16:0] m_wa  = '0;
    int          m_ln  = 0;
    logic [31:0] m_wd  = '0;
    logic        lbv   = 1'b0;
    logic [16:0] lbtag = '0;
    logic [63:0] lbdata = '0;

    function automatic logic model_hit();
        return rst && phase == 0 && mem_r_en_in && !mem_w_en_in
            && lbv && lbtag == f_wa(alu_res);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            phase <= 0;
            lbv   <= 1'b0;
        end else if (phase == 0) begin
            if (mem_w_en_in || (mem_r_en_in && !model_hit())) begin
                phase <= 1;
                op_rd <= !mem_w_en_in;
                m_wa  <= f_wa(alu_res);
                m_ln  <= f_ln(alu_res);
                m_wd  <= val_rm;
            end
        end else if (phase < W) begin
            phase <= phase + 1;
        end else if (phase == W) begin
            phase <= W + 1;
            if (op_rd) begin
                lbv    <= 1'b1;
                lbtag  <= m_wa;
                lbdata <= mdl_mem[m_wa[3:0]];
            end else begin
                mdl_mem[m_wa[3:0]][m_ln*32 +: 32] <= m_wd;
                if (lbv && lbtag == m_wa) lbdata[m_ln*32 +: 32] <= m_wd;
            end
        end else begin
            phase <= 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic        e_rdy, act;
        logic [31:0] e_mo;
        logic [7:0]  e_be;
        if (!rst) begin
            e_rdy = 1'b1;
            e_mo  = '0;
        end else if (phase == 0) begin
            e_rdy = model_hit() || !(mem_r_en_in || mem_w_en_in);
            e_mo  = model_hit() ? lbdata[f_ln(alu_res)*32 +: 32] : 32'h0;
        end else if (phase == W + 1) begin
            e_rdy = 1'b1;
            e_mo  = op_rd ? lbdata[m_ln*32 +: 32] : 32'h0;
        end else begin
            e_rdy = 1'b0;
            e_mo  = '0;
        end
        act  = (phase >= 1 && phase <= W);
        e_be = (act && !op_rd) ? ((m_ln == 1) ? 8'h0F : 8'hF0) : 8'hFF;
        chk("m_ready", 64'(ready), 64'(e_rdy));
        chk("m_mem_out", 64'(mem_out), 64'(e_mo));
        chk("m_ce_n", 64'(sram_ce_n), 64'(!act));
        chk("m_oe_n", 64'(sram_oe_n), 64'(!(act && op_rd)));
        chk("m_we_n", 64'(sram_we_n), 64'(!(act && !op_rd)));
        chk("m_be_n", 64'(sram_be_n), 64'(e_be));
        if (act) chk("m_addr", 64'(sram_addr), 64'(m_wa));
        if (act && !op_rd)
            chk("m_dq", 64'(sram_dq[m_ln*32 +: 32]), 64'(m_wd));
        chk("m_pt_ren", 64'(mem_r_en_out), 64'(mem_r_en_in));
        chk("m_pt_wb", 64'(wb_en_out), 64'(wb_en_in));
        chk("m_pt_dest", 64'(dest_out), 64'(dest_in));
        chk("m_pt_alu", 64'(alu_res_out), 64'(alu_res));
    endtask

    task automatic sample();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] dst,
                         input logic wb);
        mem_r_en_in = r;
        mem_w_en_in = w;
        alu_res     = a;
        val_rm      = d;
        dest_in     = dst;
        wb_en_in    = wb;
    endtask

    // Runs one request until ready; snapshots the first strobe cycle.
    task automatic run_req(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] dst,
                           output int lat, output logic [31:0] mo,
                           output logic s_we, output logic s_oe,
                           output logic [7:0] s_be,
                           output logic [31:0] s_dqhi,
                           output logic [16:0] s_addr,
                           output logic oe_seen);
        logic got = 1'b0;
        drive(r, w, a, d, dst, r | w);
        lat = 0;
        mo = '0;
        s_we = 1'b1; s_oe = 1'b1; s_be = 8'hFF;
        s_dqhi = '0; s_addr = '0; oe_seen = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            sample();
            if (!sram_oe_n) oe_seen = 1'b1;
            if (lat == 1) begin
                s_we = sram_we_n; s_oe = sram_oe_n; s_be = sram_be_n;
                s_dqhi = sram_dq[63:32]; s_addr = sram_addr;
            end
            if (ready) begin
                mo  = mem_out;
                got = 1'b1;
                if (lat == W + 1) s_addr = sram_addr;
            end else begin
                lat++;
            end
            adv();
        end
        if (!got) chk("timeout", 64'(ready), 64'd1);
    endtask

    int          lat;
    logic [31:0] mo, dqhi;
    logic        swe, soe, oes;
    logic [7:0]  sbe;
    logic [16:0] sad;

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sample();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_strobes", 64'({sram_we_n, sram_oe_n, sram_ce_n}), 64'h7);
        chk("rst_be_n", 64'(sram_be_n), 64'hFF);
        chk("rst_mem_out", 64'(mem_out), 64'h0);
        adv();
        rst = 1'b1;
        sample();
        adv();

        run_req(1, 0, 32'd1032, 32'h0, 4'd3, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("miss_lat", 64'(lat), 64'd6);
        chk("miss_data", 64'(mo), 64'h12345678);
        chk("miss_addr", 64'(sad), 64'd1);
        chk("miss_oe", 64'(soe), 64'd0);

        run_req(1, 0, 32'd1036, 32'h0, 4'd4, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("hit_lat", 64'(lat), 64'd0);
        chk("hit_data", 64'(mo), 64'hDEADBEEF);
        chk("hit_oe", 64'(oes), 64'd0);

        run_req(0, 1, 32'd1036, 32'hCAFEF00D, 4'd5, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("wr_lat", 64'(lat), 64'd6);
        chk("wr_we", 64'(swe), 64'd0);
        chk("wr_be", 64'(sbe), 64'h0F);
        chk("wr_dq", 64'(dqhi), 64'hCAFEF00D);

        run_req(1, 0, 32'd1036, 32'h0, 4'd6, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("wt_lat", 64'(lat), 64'd0);
        chk("wt_data", 64'(mo), 64'hCAFEF00D);

        run_req(0, 0, 32'd1040, 32'h0, 4'd1, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("idle_lat", 64'(lat), 64'd0);
        chk("idle_data", 64'(mo), 64'h0);

        drive(1, 0, 32'd1040, 32'h0, 4'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sample();
            adv();
        end
        rst = 1'b0;
        sample();
        chk("rstmid_ready", 64'(ready), 64'd1);
        chk("rstmid_oe_held", 64'(sram_oe_n), 64'd0);
        adv();
        sample();
        chk("rstmid_strobes", 64'({sram_we_n, sram_oe_n, sram_ce_n}), 64'h7);
        chk("rstmid_mem_out", 64'(mem_out), 64'h0);
        adv();
        rst = 1'b1;

        run_req(1, 0, 32'd1040, 32'h0, 4'd2, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("rerd_lat", 64'(lat), 64'd6);
        chk("rerd_data", 64'(mo), 64'h89ABCDEF);

        run_req(1, 1, 32'd1032, 32'h11112222, 4'd7, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("rw_lat", 64'(lat), 64'd6);
        chk("rw_we", 64'(swe), 64'd0);
        chk("rw_oe", 64'(oes), 64'd0);
        chk("rw_be", 64'(sbe), 64'hF0);

        run_req(1, 0, 32'd1032, 32'h0, 4'd8, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("rw_rd_lat", 64'(lat), 64'd6);
        chk("rw_rd_data", 64'(mo), 64'h11112222);

        run_req(1, 0, 32'd1036, 32'h0, 4'd9, lat, mo, swe, soe, sbe, dqhi, sad, oes);
        chk("rw_hi_lat", 64'(lat), 64'd0);
        chk("rw_hi_data", 64'(mo), 64'hCAFEF00D);

        drive(0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        sample();
        adv();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
